// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types and constants; IF_PREFETCH_BUF_EN selects fetch buffer depth
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
`ifdef IF_PREFETCH_BUF_EN
    localparam int IF_DEPTH = 2;
`else
    localparam int IF_DEPTH = 1;
`endif
    localparam int DROP_W = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - imem, redirect and IF/ID bundle between fetch stage and its neighbours
interface if_stage_if;
    import riscv_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_stall;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc_plus4;

    modport slave (
        output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pc_plus4,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_stall
    );
    modport master (
        input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pc_plus4,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, id_stall
    );
endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order {pc, instr} buffer with flush; head is visible combinationally
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wdata,
    output fetch_entry_t     rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full   = (r_count == CNT_W'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rd];
    assign w_pop  = pop && !empty;
    // A push into a full buffer is only accepted when the head leaves in the same cycle
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= next_ptr(r_wr);
            if (w_pop)  r_rd <= next_ptr(r_rd);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr] <= wdata;
    end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with in-order fetch buffer; IF_PREFETCH_BUF_EN enables depth 2
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC         = 32'h0000_0000,
    parameter int              RESP_LATENCY_MIN = 1
) (
    input logic       clk,
    input logic       rst,
    if_stage_if.slave bus
);
    localparam int CNT_W  = $clog2(IF_DEPTH + 1);
    localparam int OUT_W  = 2;
    localparam int FILL_W = 3;

    generate
        if (RESP_LATENCY_MIN < 1) begin : g_bad_latency
            $error("RESP_LATENCY_MIN must be at least 1");
        end
    endgenerate

    logic [XLEN-1:0]   r_pc;
    logic [OUT_W-1:0]  r_outstanding;
    logic [DROP_W-1:0] r_drop;

    logic [CNT_W-1:0]  w_count;
    logic [FILL_W-1:0] w_fill;
    logic [DROP_W-1:0] w_in_flight;
    logic              w_full;
    logic              w_empty;
    logic              w_req_valid;
    logic              w_handshake;
    logic              w_resp_live;
    logic              w_resp_drop;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_wdata;
    fetch_entry_t      w_head;
    logic [XLEN-1:0]   w_id_pc;

    assign w_fill      = FILL_W'(w_count) + FILL_W'(r_outstanding);
    assign w_req_valid = rst && !bus.redirect_valid && (w_fill < FILL_W'(IF_DEPTH));
    assign w_handshake = w_req_valid && bus.imem_req_ready;
    assign w_resp_drop = bus.imem_resp_valid && (r_drop != '0);
    assign w_resp_live = bus.imem_resp_valid && (r_drop == '0);
    assign w_push      = w_resp_live && !bus.redirect_valid && (!w_full || w_pop);
    assign w_pop       = !w_empty && !bus.id_stall && !bus.redirect_valid;
    assign w_in_flight = r_drop + DROP_W'(r_outstanding);

    // Live requests since the last redirect are consecutive words, so the oldest one sits behind r_pc
    assign w_wdata.pc    = r_pc - XLEN'({r_outstanding, 2'b00});
    assign w_wdata.instr = bus.imem_resp_data;

    fetch_fifo #(.DEPTH(IF_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.redirect_valid),
        .wdata (w_wdata),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else if (bus.redirect_valid) begin
            r_pc          <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            r_outstanding <= '0;
            r_drop        <= (bus.imem_resp_valid && w_in_flight != '0) ? w_in_flight - DROP_W'(1) : w_in_flight;
        end else begin
            if (w_handshake) r_pc <= r_pc + XLEN'(4);
            r_outstanding <= r_outstanding + OUT_W'(w_handshake) - OUT_W'(w_resp_live);
            if (w_resp_drop) r_drop <= r_drop - DROP_W'(1);
        end
    end

    assign w_id_pc            = w_empty ? '0 : w_head.pc;
    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.id_valid       = !w_empty;
    assign bus.id_pc          = w_id_pc;
    assign bus.id_instr       = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.id_pc_plus4    = w_id_pc + XLEN'(4);
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with an in-order imem model (data = address)
module tb_if_stage;
    import riscv_pkg::*;
`ifdef IF_PREFETCH_BUF_EN
    localparam int AHEAD = 1;
`else
    localparam int AHEAD = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000), .RESP_LATENCY_MIN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    logic        held = 1'b0;
    logic [31:0] held_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // imem model: accepts at the posedge after a valid&&ready sample, answers mem_lat cycles later
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = pend[0].addr;
                pend.delete(0);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            #1;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back('{bus.imem_req_addr, cyc + mem_lat});
                req_log.push_back(bus.imem_req_addr);
            end
        end
    end

    // monitor: request stability and IF/ID consumption against the scoreboard
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #1;
            if (held && rst && !bus.redirect_valid) begin
                check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
                check("req_hold_addr", bus.imem_req_addr, held_addr);
            end
            held      = rst && bus.imem_req_valid && !bus.imem_req_ready;
            held_addr = bus.imem_req_addr;
            if (rst && bus.id_valid && !bus.id_stall && !bus.redirect_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=%h required=none", bus.id_pc);
                end else begin
                    exp_pc = sb.pop_front();
                    check("id_pc", bus.id_pc, exp_pc);
                    check("id_instr", bus.id_instr, exp_pc);
                    check("id_pc_plus4", bus.id_pc_plus4, exp_pc + 32'd4);
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        @(negedge clk);
        bus.id_stall = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.id_stall = 1'b1;
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic quiesce();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pend.size() != 0 || bus.imem_resp_valid) && n < 50);
        check("quiesce_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic wait_pend(input int target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pend.size() < target && n < 50);
        check("wait_pend_timeout", 32'(pend.size() >= target), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] target);
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
        check({tag, "_id_pc"}, bus.id_pc, 32'h0);
        check({tag, "_id_instr"}, bus.id_instr, 32'h0000_0013);
        check({tag, "_id_pc_plus4"}, bus.id_pc_plus4, 32'h4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;
        rst                = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_stall       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");

        // release with memory busy: request must appear at once and hold
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("first_req_addr", bus.imem_req_addr, 32'h0);
        repeat (3) @(negedge clk);
        bus.imem_req_ready = 1'b1;

        sb.push_back(32'h0);
        sb.push_back(32'h4);
        drain();

        // stalled at pc 8: prefetch build fetches exactly one more word
        repeat (6) @(negedge clk);
        check("ahead_req_count", 32'(req_log.size()), 32'(3 + AHEAD));
        check("ahead_last_addr", req_log[req_log.size() - 1], 32'(8 + 4 * AHEAD));
        repeat (3) begin
            @(negedge clk);
            #1;
            check("stall_id_valid", 32'(bus.id_valid), 32'd1);
            check("stall_id_pc", bus.id_pc, 32'h8);
            check("stall_id_instr", bus.id_instr, 32'h8);
        end
        sb.push_back(32'h8);
        sb.push_back(32'hC);
        sb.push_back(32'h10);
        drain();

        // redirect under stall with responses outstanding, then back-to-back redirect
        quiesce();
        mem_lat = 3;
        redirect(32'h40);
        #1;
        check("flush_id_valid", 32'(bus.id_valid), 32'd0);
        wait_pend(1 + AHEAD);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h180;
        @(negedge clk);
        bus.redirect_pc    = 32'h103;
        idx = req_log.size();
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("b2b_id_valid", 32'(bus.id_valid), 32'd0);
        check("b2b_id_instr", bus.id_instr, 32'h0000_0013);
        sb.push_back(32'h100);
        sb.push_back(32'h104);
        drain();
        check("redirect_align", (req_log.size() > idx) ? req_log[idx] : 32'hFFFF_FFFF, 32'h100);

        // redirect landing in the same cycle as a response
        quiesce();
        mem_lat = 1;
        redirect(32'h200);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.imem_resp_valid && n < 20);
        check("resp_seen", 32'(bus.imem_resp_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        check("coincide_id_valid", 32'(bus.id_valid), 32'd0);
        sb.push_back(32'h300);
        sb.push_back(32'h304);
        drain();

        // pc wraps at the top of the address space
        quiesce();
        redirect(32'hFFFF_FFFC);
        sb.push_back(32'hFFFF_FFFC);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        drain();

        // reset with a request in flight; its response lands while reset is held
        quiesce();
        mem_lat = 3;
        redirect(32'h500);
        wait_pend(1);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        quiesce();
        #1;
        check_reset_outputs("midreset_late");
        @(negedge clk);
        mem_lat = 1;
        rst = 1'b1;
        #1;
        check("restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("restart_req_addr", bus.imem_req_addr, 32'h0);
        sb.push_back(32'h0);
        sb.push_back(32'h4);
        drain();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
